// File: rtl/up_down_cnt_9999.sv
// ============================================================================
// Module   : up_down_cnt_9999
// Function : Tick-driven decimal up/down counter (0..MAX_CNT) with a
//            run/stop/clear FSM, direction toggle and registered BCD image.
//            Define CNT_WRAP_FLAG_EN to add the o_wrap pulse output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module up_down_cnt_9999 #(
    parameter int MAX_CNT = 9999,
    parameter int CNT_W   = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_btn_run,
    input  logic             i_btn_clear,
    input  logic             i_btn_mode,
    output logic [CNT_W-1:0] o_count,
    output logic [15:0]      o_bcd,
    output logic             o_mode,
    output logic             o_run
`ifdef CNT_WRAP_FLAG_EN
    ,
    output logic             o_wrap
`endif
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_CNT);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q,  mode_d;
    logic             run_q;
    logic [15:0]      bcd_q,   bcd_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q ^ i_btn_mode;
        case (state_q)
            ST_STOP: begin
                if (i_btn_run) begin
                    state_d = ST_RUN;
                end else if (i_btn_clear) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                // The tick always uses the mode in force before this cycle.
                if (i_tick) begin
                    if (!mode_q) begin
                        count_d = (count_q == C_MAX) ? '0 : count_q + CNT_W'(1);
                    end else begin
                        count_d = (count_q == '0) ? C_MAX : count_q - CNT_W'(1);
                    end
                end
                if (i_btn_run) begin
                    state_d = ST_STOP;
                end
            end
            ST_CLEAR: begin
                count_d = '0;
                state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Double-dabble binary to 4-digit BCD; count is bounded to 9999.
    always_comb begin
        bcd_d = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd_d[4*d +: 4] >= 4'd5) begin
                    bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
                end
            end
            bcd_d = {bcd_d[14:0], count_q[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            count_q <= '0;
            mode_q  <= 1'b0;
            run_q   <= 1'b0;
            bcd_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            run_q   <= (state_d == ST_RUN);
            bcd_q   <= bcd_d;
        end
    end

    assign o_count = count_q;
    assign o_bcd   = bcd_q;
    assign o_mode  = mode_q;
    assign o_run   = run_q;

`ifdef CNT_WRAP_FLAG_EN
    logic w_wrap;
    logic wrap_q;

    assign w_wrap = (state_q == ST_RUN) && i_tick &&
                    (mode_q ? (count_q == '0) : (count_q == C_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= w_wrap;
        end
    end

    assign o_wrap = wrap_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_up_down_cnt_9999.sv
// Testbench for up_down_cnt_9999: table-driven vectors plus clear/reset sequences.
`default_nettype none

module tb_up_down_cnt_9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tick, i_btn_run, i_btn_clear, i_btn_mode;
    logic [13:0] o_count;
    logic [15:0] o_bcd;
    logic        o_mode, o_run;
`ifdef CNT_WRAP_FLAG_EN
    logic        o_wrap;
`endif

    up_down_cnt_9999 #(.MAX_CNT(9999), .CNT_W(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (i_tick),
        .i_btn_run   (i_btn_run),
        .i_btn_clear (i_btn_clear),
        .i_btn_mode  (i_btn_mode),
        .o_count     (o_count),
        .o_bcd       (o_bcd),
        .o_mode      (o_mode),
        .o_run       (o_run)
`ifdef CNT_WRAP_FLAG_EN
        ,
        .o_wrap      (o_wrap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit t, r, c, m;
        int cnt;
        bit run, mode, wrap;
    } vec_t;

    vec_t vq[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   prev    = 0;
    bit   prev_ok = 1'b1;

    function automatic int to_bcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
               ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input bit t, r, c, m, input int cnt, input bit run, mode, wrap);
        vq.push_back(vec_t'{t, r, c, m, cnt, run, mode, wrap});
    endtask

    // Drive one cycle of inputs, check just after the edge, return at negedge.
    task automatic step(input bit t, r, c, m, input int ecnt, input bit erun, emode, ewrap,
                        input bit chk_cnt, input string tag);
        i_tick = t; i_btn_run = r; i_btn_clear = c; i_btn_mode = m;
        @(posedge clk);
        #1;
        i_tick = 0; i_btn_run = 0; i_btn_clear = 0; i_btn_mode = 0;
        if (chk_cnt) begin
            chk({tag, ".count"}, int'(o_count), ecnt);
            if (prev_ok) chk({tag, ".bcd"}, int'(o_bcd), to_bcd(prev));
            prev    = ecnt;
            prev_ok = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
        chk({tag, ".run"},  int'(o_run),  int'(erun));
        chk({tag, ".mode"}, int'(o_mode), int'(emode));
`ifdef CNT_WRAP_FLAG_EN
        chk({tag, ".wrap"}, int'(o_wrap), int'(ewrap));
`endif
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        i_tick = 0; i_btn_run = 0; i_btn_clear = 0; i_btn_mode = 0;

        // Table: t r c m | count run mode wrap
        add(0,1,0,0, 0,1,0,0);
        for (int k = 1; k <= 12; k++) add(1,0,0,0, k,1,0,0);
        add(0,0,0,0, 12,1,0,0);
        add(1,1,0,0, 13,0,0,0);
        add(1,0,0,0, 13,0,0,0);
        add(0,1,1,0, 13,1,0,0);
        add(0,0,1,0, 13,1,0,0);
        add(1,0,0,0, 14,1,0,0);
        add(0,1,0,0, 14,0,0,0);
        add(0,0,0,1, 14,0,1,0);
        add(0,1,0,0, 14,1,1,0);
        add(1,0,0,0, 13,1,1,0);
        add(1,0,0,1, 12,1,0,0);
        add(1,0,0,0, 13,1,0,0);
        add(0,0,0,1, 13,1,1,0);
        for (int k = 12; k >= 0; k--) add(1,0,0,0, k,1,1,0);
        add(1,0,0,0, 9999,1,1,1);
        add(0,0,0,0, 9999,1,1,0);
        add(1,0,0,0, 9998,1,1,0);
        add(0,0,0,1, 9998,1,0,0);
        add(1,0,0,0, 9999,1,0,0);
        add(1,0,0,0, 0,1,0,1);
        add(0,0,0,0, 0,1,0,0);
        add(0,1,0,0, 0,0,0,0);
        add(1,1,0,0, 0,1,0,0);
        add(0,1,0,0, 0,0,0,0);

        repeat (3) @(negedge clk);
        chk("reset.count", int'(o_count), 0);
        chk("reset.bcd",   int'(o_bcd),   0);
        chk("reset.run",   int'(o_run),   0);
        chk("reset.mode",  int'(o_mode),  0);
`ifdef CNT_WRAP_FLAG_EN
        chk("reset.wrap",  int'(o_wrap),  0);
`endif
        rst = 1'b0;
        @(negedge clk);

        foreach (vq[i])
            step(vq[i].t, vq[i].r, vq[i].c, vq[i].m,
                 vq[i].cnt, vq[i].run, vq[i].mode, vq[i].wrap, 1'b1, $sformatf("vec%0d", i));

        // Clear: ignored in RUN, honoured in STOP, buttons except mode ignored in CLEAR.
        step(0,1,0,0, 0,1,0,0, 1'b1, "clr.run");
        for (int k = 1; k <= 5; k++) step(1,0,0,0, k,1,0,0, 1'b1, "clr.tick");
        step(0,0,1,0, 5,1,0,0, 1'b1, "clr.inrun");
        step(0,1,0,0, 5,0,0,0, 1'b1, "clr.stop");
        step(0,0,1,0, 0,0,0,0, 1'b0, "clr.pulse");
        step(0,1,0,1, 0,0,1,0, 1'b1, "clr.incl");
        step(0,0,0,1, 0,0,0,0, 1'b1, "clr.mode");
        for (int k = 0; k < 3; k++) step(1,0,0,0, 0,0,0,0, 1'b1, "clr.idle");

        // Asynchronous reset mid-count at 42, running, down.
        step(0,1,0,0, 0,1,0,0, 1'b1, "ar.run");
        for (int k = 1; k <= 42; k++) step(1,0,0,0, k,1,0,0, 1'b1, "ar.tick");
        step(0,0,0,1, 42,1,1,0, 1'b1, "ar.down");
        #2 rst = 1'b1;
        #1;
        chk("ar.count", int'(o_count), 0);
        chk("ar.bcd",   int'(o_bcd),   0);
        chk("ar.run",   int'(o_run),   0);
        chk("ar.mode",  int'(o_mode),  0);
`ifdef CNT_WRAP_FLAG_EN
        chk("ar.wrap",  int'(o_wrap),  0);
`endif
        @(negedge clk);
        rst  = 1'b0;
        prev = 0;
        for (int k = 0; k < 3; k++) step(1,0,0,0, 0,0,0,0, 1'b1, "ar.idle");
        step(0,1,0,0, 0,1,0,0, 1'b1, "ar.rerun");
        step(1,0,0,0, 1,1,0,0, 1'b1, "ar.tick1");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
